// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
// Circular FIFO of fetched instruction pairs between fetch and the dual-issue
// decoder. The oldest pair is presented to decode. A split issue lets decode
// take only the first instruction; the second is then presented alone.
// Optional feature: define IFB_BYPASS_EN so that, while the buffer is empty,
// a pushed pair drives the decode outputs combinationally in the same cycle.
module instr_fetch_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fetchValid_IF,
    output logic                  fetchReady_IF,
    input  logic [PC_WIDTH-1:0]   pc_IF,
    input  logic [31:0]           instr_IF1,
    input  logic [31:0]           instr_IF2,
    input  logic [1:0]            consume_ID,
    output logic                  valid_ID,
    output logic                  instr2Valid_ID,
    output logic [31:0]           instr_ID1,
    output logic [31:0]           instr_ID2,
    output logic [PC_WIDTH-1:0]   pc_ID,
    output logic [$clog2(DEPTH):0] count
);

    localparam int                PW      = $clog2(DEPTH);
    localparam logic [31:0]       SPU_NOP = 32'h4020_0000;
    localparam logic [PW:0]       DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

    logic [PC_WIDTH-1:0] pc_mem [DEPTH];
    logic [31:0]         i1_mem [DEPTH];
    logic [31:0]         i2_mem [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          split_head;

    logic push;
    logic bypass;
    logic take_first;
    logic take_both;
    logic do_push;
    logic do_pop;
    logic set_split;

    // Ready comes from the registered count only, so decode cannot reach fetch.
    assign fetchReady_IF = (count < DEPTH_C);
    assign push          = fetchValid_IF && fetchReady_IF && !flush;

`ifdef IFB_BYPASS_EN
    // Empty buffer plus a push: fetch inputs go straight to decode this cycle.
    assign bypass = push && (count == '0) && reset;
`else
    assign bypass = 1'b0;
`endif

    // Reserved encoding 3 and any request while nothing is valid are ignored.
    assign take_first = valid_ID && (consume_ID == 2'd1);
    assign take_both  = valid_ID && (consume_ID == 2'd2);

    // A bypassed pair fully consumed by decode never needs a storage slot.
    assign do_push   = push && !(bypass && take_both);
    assign do_pop    = !flush && (count != '0) && (take_both || (take_first && split_head));
    assign set_split = !flush && take_first && !split_head;

    // Head presentation: stored head entry, else bypassed fetch pair, else zeros.
    always_comb begin
        // NOTE: every output gets a default first so no branch can infer a latch.
        valid_ID       = 1'b0;
        instr2Valid_ID = 1'b0;
        instr_ID1      = '0;
        instr_ID2      = '0;
        pc_ID          = '0;
        if (count != '0) begin
            valid_ID = 1'b1;
            if (split_head) begin
                instr_ID1 = i2_mem[head];
                instr_ID2 = SPU_NOP;
                pc_ID     = pc_mem[head] + PC_STEP;
            end else begin
                instr2Valid_ID = 1'b1;
                instr_ID1      = i1_mem[head];
                instr_ID2      = i2_mem[head];
                pc_ID          = pc_mem[head];
            end
        end else if (bypass) begin
            valid_ID       = 1'b1;
            instr2Valid_ID = 1'b1;
            instr_ID1      = instr_IF1;
            instr_ID2      = instr_IF2;
            pc_ID          = pc_IF;
        end
    end

    // Pair storage write at the tail.
    // NOTE: storage has no reset; count marks which slots hold real data, so
    // stale contents are never presented.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[tail] <= pc_IF;
            i1_mem[tail] <= instr_IF1;
            i2_mem[tail] <= instr_IF2;
        end
    end

    // Pointer, occupancy and split-state update; flush empties the buffer.
    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            split_head <= 1'b0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            split_head <= 1'b0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (do_pop)         split_head <= 1'b0;
            else if (set_split) split_head <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Testbench for instr_fetch_buffer: directed scenarios plus random traffic,
// checked against a queue-based model of the buffer.
module tb_instr_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP   = 32'h4020_0000;

    typedef logic [1+1+32+32+32+CW+1-1:0] ov_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          fetchValid_IF = 1'b0;
    logic          fetchReady_IF;
    logic [31:0]   pc_IF = '0;
    logic [31:0]   instr_IF1 = '0;
    logic [31:0]   instr_IF2 = '0;
    logic [1:0]    consume_ID = '0;
    logic          valid_ID;
    logic          instr2Valid_ID;
    logic [31:0]   instr_ID1;
    logic [31:0]   instr_ID2;
    logic [31:0]   pc_ID;
    logic [CW-1:0] count;

    int   asserts = 0;
    int   fails = 0;
    ent_t q[$];
    bit   m_split = 1'b0;
    ov_t  exp;
    ov_t  obs;

    instr_fetch_buffer #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fetchValid_IF(fetchValid_IF), .fetchReady_IF(fetchReady_IF),
        .pc_IF(pc_IF), .instr_IF1(instr_IF1), .instr_IF2(instr_IF2),
        .consume_ID(consume_ID), .valid_ID(valid_ID), .instr2Valid_ID(instr2Valid_ID),
        .instr_ID1(instr_ID1), .instr_ID2(instr_ID2), .pc_ID(pc_ID), .count(count)
    );

    always #5 clk = ~clk;

    assign obs = {valid_ID, instr2Valid_ID, instr_ID1, instr_ID2, pc_ID, count, fetchReady_IF};

    // Same-cycle bypass applies only to an empty buffer taking a push.
    function automatic bit m_bypass();
`ifdef IFB_BYPASS_EN
        return (q.size() == 0) && fetchValid_IF && !flush && reset;
`else
        return 1'b0;
`endif
    endfunction

    // Expected decode-side view for the current inputs and model state.
    function automatic ov_t model_out();
        logic        v, v2;
        logic [31:0] a, b, p;
        v = 1'b0; v2 = 1'b0; a = '0; b = '0; p = '0;
        if (q.size() > 0) begin
            v = 1'b1;
            if (m_split) begin
                a = q[0].i2; b = NOP; p = q[0].pc + 32'd4;
            end else begin
                v2 = 1'b1; a = q[0].i1; b = q[0].i2; p = q[0].pc;
            end
        end else if (m_bypass()) begin
            v = 1'b1; v2 = 1'b1; a = instr_IF1; b = instr_IF2; p = pc_IF;
        end
        return {v, v2, a, b, p, CW'(q.size()), (q.size() < DEPTH)};
    endfunction

    // Apply the rules of one clock edge to the model.
    task automatic model_edge();
        bit push, byp, valid;
        int eff;
        push  = fetchValid_IF && (q.size() < DEPTH) && !flush;
        byp   = m_bypass();
        valid = (q.size() > 0) || byp;
        eff   = (valid && consume_ID != 2'd3) ? int'(consume_ID) : 0;
        if (flush) begin
            q.delete();
            m_split = 1'b0;
        end else if (byp) begin
            if (eff != 2) begin
                q.push_back('{pc_IF, instr_IF1, instr_IF2});
                m_split = (eff == 1);
            end
        end else begin
            if (eff == 2 || (eff == 1 && m_split)) begin
                q.delete(0);
                m_split = 1'b0;
            end else if (eff == 1) begin
                m_split = 1'b1;
            end
            if (push) q.push_back('{pc_IF, instr_IF1, instr_IF2});
        end
    endtask

    task automatic drive(input bit fv, input logic [31:0] p, input logic [1:0] c, input bit f);
        @(negedge clk);
        fetchValid_IF = fv;
        pc_IF         = p;
        instr_IF1     = $urandom;
        instr_IF2     = $urandom;
        consume_ID    = c;
        flush         = f;
        #1 exp = model_out();
    endtask

    task automatic advance();
        model_edge();
        @(posedge clk);
    endtask

    task automatic test_reset();
        #1;
        asserts++;
        if (obs !== ov_t'(1)) begin fails++; $display("FAIL reset_init got=%h want=%h", obs, ov_t'(1)); end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10 + 32'(i * 8), 2'd0, 1'b0);
            asserts++;
            if (obs !== exp) begin fails++; $display("FAIL reset_fill[%0d] got=%h want=%h", i, obs, exp); end
            advance();
        end
        drive(1'b1, 32'h50, 2'd2, 1'b0);
        #2 reset = 1'b0;
        fetchValid_IF = 1'b0;
        consume_ID    = 2'd0;
        #1;
        asserts++;
        if ({count, valid_ID, fetchReady_IF} !== {CW'(0), 1'b0, 1'b1}) begin
            fails++; $display("FAIL reset_mid count=%0d valid=%b ready=%b want 0/0/1", count, valid_ID, fetchReady_IF);
        end
        q.delete();
        m_split = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h100, 2'd0, 1'b0);
        advance();
        drive(1'b0, 32'h0, 2'd0, 1'b0);
        asserts++;
        if ({valid_ID, pc_ID} !== {1'b1, 32'h100}) begin
            fails++; $display("FAIL reset_first_push valid=%b pc=%h want 1/00000100", valid_ID, pc_ID);
        end
        advance();
    endtask

    task automatic test_full();
        drive(1'b0, 32'h0, 2'd0, 1'b1);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h1000 + 32'(i * 8), 2'd0, 1'b0);
            asserts++;
            if (obs !== exp) begin fails++; $display("FAIL full_fill[%0d] got=%h want=%h", i, obs, exp); end
            advance();
        end
        drive(1'b1, 32'h2000, 2'd2, 1'b0);
        asserts++;
        if ({count, fetchReady_IF} !== {CW'(4), 1'b0}) begin
            fails++; $display("FAIL full_state count=%0d ready=%b want 4/0", count, fetchReady_IF);
        end
        advance();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 2'd2, 1'b0);
            asserts++;
            if (obs !== exp) begin fails++; $display("FAIL full_drain[%0d] got=%h want=%h", i, obs, exp); end
            if (i == 0) begin
                asserts++;
                if ({count, pc_ID} !== {CW'(3), 32'h1008}) begin
                    fails++; $display("FAIL full_pop_no_write count=%0d pc=%h want 3/00001008", count, pc_ID);
                end
            end
            advance();
        end
    endtask

    task automatic test_split();
        logic [31:0] b_instr;
        drive(1'b1, 32'h200, 2'd0, 1'b0);
        b_instr = instr_IF2;
        advance();
        drive(1'b1, 32'h208, 2'd1, 1'b0);
        asserts++;
        if (obs !== exp) begin fails++; $display("FAIL split_head got=%h want=%h", obs, exp); end
        advance();
        drive(1'b0, 32'h0, 2'd1, 1'b0);
        asserts++;
        if ({instr_ID1, instr_ID2, pc_ID, instr2Valid_ID} !== {b_instr, NOP, 32'h204, 1'b0}) begin
            fails++; $display("FAIL split_second got=%h/%h/%h/%b want=%h/%h/00000204/0",
                              instr_ID1, instr_ID2, pc_ID, instr2Valid_ID, b_instr, NOP);
        end
        advance();
        drive(1'b0, 32'h0, 2'd2, 1'b0);
        asserts++;
        if ({pc_ID, instr2Valid_ID, count} !== {32'h208, 1'b1, CW'(1)}) begin
            fails++; $display("FAIL split_pop pc=%h i2v=%b count=%0d want 00000208/1/1", pc_ID, instr2Valid_ID, count);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h3000, 2'd0, 1'b0);
        advance();
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h3000 + 32'(i * 8), 2'd2, 1'b0);
            asserts++;
            if ({count, pc_ID, obs} !== {CW'(1), 32'h3000 + 32'((i - 1) * 8), exp}) begin
                fails++; $display("FAIL b2b[%0d] count=%0d pc=%h got=%h want=%h", i, count, pc_ID, obs, exp);
            end
            advance();
        end
        drive(1'b0, 32'h0, 2'd2, 1'b0);
        advance();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h4000 + 32'(i * 8), 2'd0, 1'b0);
            advance();
        end
        drive(1'b1, 32'h4100, 2'd2, 1'b1);
        advance();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 2'd0, 1'b0);
            asserts++;
            if ({count, valid_ID, obs} !== {CW'(0), 1'b0, exp}) begin
                fails++; $display("FAIL flush[%0d] count=%0d valid=%b got=%h want=%h", i, count, valid_ID, obs, exp);
            end
            advance();
        end
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h300, 2'd2, 1'b0);
`ifdef IFB_BYPASS_EN
        asserts++;
        if ({valid_ID, pc_ID, count} !== {1'b1, 32'h300, CW'(0)}) begin
            fails++; $display("FAIL bypass_same valid=%b pc=%h count=%0d want 1/00000300/0", valid_ID, pc_ID, count);
        end
        advance();
        drive(1'b0, 32'h0, 2'd0, 1'b0);
        asserts++;
        if ({valid_ID, count} !== {1'b0, CW'(0)}) begin
            fails++; $display("FAIL bypass_next valid=%b count=%0d want 0/0", valid_ID, count);
        end
`else
        asserts++;
        if (valid_ID !== 1'b0) begin fails++; $display("FAIL nobypass_same valid=%b want 0", valid_ID); end
        advance();
        drive(1'b0, 32'h0, 2'd0, 1'b0);
        asserts++;
        if ({valid_ID, pc_ID, count} !== {1'b1, 32'h300, CW'(1)}) begin
            fails++; $display("FAIL nobypass_next valid=%b pc=%h count=%0d want 1/00000300/1", valid_ID, pc_ID, count);
        end
`endif
        advance();
        drive(1'b0, 32'h0, 2'd0, 1'b1);
        advance();
    endtask

    task automatic test_random();
        logic [31:0] p;
        for (int i = 0; i < 400; i++) begin
            p = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive($urandom_range(0, 3) != 0, p, 2'($urandom_range(0, 3)), $urandom_range(0, 31) == 0);
            asserts++;
            if (obs !== exp) begin fails++; $display("FAIL random[%0d] got=%h want=%h", i, obs, exp); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_split();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_buffer.md
# instr_fetch_buffer

- Sits between instruction fetch and the dual-issue decoder, upstream of the ID/REG pipeline register.
- Buffers up to DEPTH fetched instruction pairs (two 32-bit SPU instructions per pair) in a circular FIFO and presents the oldest pair to decode.
- Supports split issue: the decoder takes only the first instruction and the second is re-presented alone.
- Absorbs decode stalls and discards all contents on a branch flush.

## Interface

Parameters:
- DEPTH, 4, number of pair entries; power of two, ≥2
- PC_WIDTH, 32, width of the instruction address

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  discard all entries (branch redirect)
- fetchValid_IF  in  1  fetch offers a pair this cycle
- fetchReady_IF  out  1  buffer accepts a pair this cycle
- pc_IF  in  PC_WIDTH  address of instr_IF1; instr_IF2 is at pc_IF+4
- instr_IF1, instr_IF2  in  32 each  fetched instructions
- consume_ID  in  2  decoder take: 0 none, 1 first only, 2 both, 3 reserved (treated as 0)
- valid_ID  out  1  head pair is valid
- instr2Valid_ID  out  1  instr_ID2 holds a real instruction (0 after a split)
- instr_ID1, instr_ID2  out  32 each  head instructions
- pc_ID  out  PC_WIDTH  address of instr_ID1
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation

- Storage:
  - DEPTH entries of {pc, instr1, instr2}.
  - Head pointer, tail pointer, count register, one splitHead flag.
- Push:
  - Condition: fetchValid_IF && fetchReady_IF && !flush.
  - Writes the entry at tail; tail and count increment.
- fetchReady_IF = (count < DEPTH). It depends only on registered state, with no path from consume_ID.
- Consume is ignored when valid_ID=0.
- Head presentation:
  - splitHead=0: instr_ID1=instr1, instr_ID2=instr2, pc_ID=pc, instr2Valid_ID=1.
  - splitHead=1: instr_ID1=instr2, instr_ID2=32'h40200000 (SPU nop), pc_ID=pc+4, instr2Valid_ID=0.
- consume_ID=1:
  - With splitHead=0: set splitHead; no pop.
  - With splitHead=1: pop.
- consume_ID=2: pop regardless of splitHead.
- Pop: head increments (wraps modulo DEPTH), count decrements, splitHead clears.
- Push and pop in the same cycle: count unchanged, both pointers advance.
  - When full, push is blocked because fetchReady_IF=0, even if a pop occurs that cycle.
- Flush (synchronous): head=tail=0, count=0, splitHead=0; any same-cycle push or consume is discarded.
- When valid_ID=0, instr_ID1, instr_ID2, pc_ID and instr2Valid_ID are forced to 0.
- pc arithmetic (pc+4) wraps modulo 2^PC_WIDTH.

## Timing

- Reset (async, asserted low), all at once:
  - count=0, head=0, tail=0, splitHead=0, valid_ID=0, fetchReady_IF=1.
  - instr_ID1=0, instr_ID2=0, pc_ID=0, instr2Valid_ID=0.
  - Storage contents need no reset.
- Reset deasserted mid-operation: buffer starts empty; in-flight pairs are lost.
- Latency without bypass: a pair pushed at edge N is presented (valid_ID=1) after edge N. There is no combinational path fetch→decode.
- A split takes effect at the edge; the second instruction is presented the following cycle.
- Throughput:
  - One pair pushed and one pair popped per cycle sustained.
  - Split issue halves consumption of that entry.
- Flush and reset override all other events in their cycle.

## Configuration

- Macro: IFB_BYPASS_EN.
- Defined: when count==0 and a push occurs, the fetch inputs drive the head outputs combinationally in the same cycle (valid_ID=1).
  - Same-cycle consume_ID=2: the pair is not written; count stays 0.
  - Same-cycle consume_ID=1: the pair is written with splitHead=1.
  - Same-cycle consume_ID=0: normal write.
  - flush still suppresses the bypass.
- Undefined: no bypass; minimum fetch-to-decode latency is one cycle.

## Test plan

- Reset low mid-traffic with count=3 → count=0, valid_ID=0, fetchReady_IF=1 immediately; after release, the first push of pc=0x100 shows pc_ID=0x100 next cycle.
- Push 4 pairs with consume_ID=0 → count=4, fetchReady_IF=0; a 5th fetchValid_IF is dropped; consume_ID=2 and fetchValid_IF in the same cycle → count=3, no write.
- Head pc=0x200, instrs A/B, consume_ID=1 → next cycle instr_ID1=B, instr_ID2=0x40200000, pc_ID=0x204, instr2Valid_ID=0; consume_ID=1 again → pops to the next entry.
- Continuous push and consume_ID=2 for 10 cycles with DEPTH=4 → pointers wrap, count stays 1, pc_IDs in push order.
- count=3, flush with simultaneous fetchValid_IF and consume_ID=2 → count=0, valid_ID=0, the new pair is not stored.
- With IFB_BYPASS_EN, empty buffer, push pc=0x300 with consume_ID=2 → valid_ID=1 that cycle, pc_ID=0x300, count stays 0; without the macro → valid_ID=0 that cycle, 1 next.
